fetch_pred_pc: RTL
==================

Name: fetch_pred_pc

Overview:
Fetch-side producer of F_predPC, the value consumed by the PC-select logic. Each cycle it predicts the next PC from the instruction currently being fetched and holds it in the F pipeline register. It adds a small return-address stack (RAS) so that ret is predicted early instead of always waiting for W_valM. Correctness still rests on the existing redirect paths (M-stage not-taken jXX, W-stage ret), so a RAS mistake only costs cycles.

Parameters:
RAS_DEPTH, 8, number of return-address entries (power of two, >=2)
PTR_W, 3, log2(RAS_DEPTH); width of the stack index

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
F_stall_i  input  1  F register hold from hazard control; no RAS op while high
f_icode_i  input  4  icode of instruction at f_pc
f_instr_valid_i  input  1  0 on imem error or invalid instruction
f_valC_i  input  64  constant word of fetched instruction
f_valP_i  input  64  fall-through PC of fetched instruction
M_icode_i  input  4  M-stage icode
M_Cnd_i  input  1  M-stage condition; IJXX with 0 = mispredict
W_icode_i  input  4  W-stage icode; commit of call/ret
F_predPC_o  output  64  registered predicted PC (F register)
f_ras_hit_o  output  1  combinational; current ret predicted from RAS
ras_count_o  output  PTR_W+1  registered speculative occupancy

Behaviour:
- Reset (async, rst_n_i low): F_predPC_o=0, spec ptr/count=0, committed ptr/count=0, ras_count_o=0. RAS entry storage is not reset; it is never read while count=0.
- Prediction (combinational, f_predPC), with icode codes from `define.v`:
  - Invalid fetch (f_instr_valid_i=0): f_valP_i; no RAS op.
  - `ICALL: f_valC_i; push f_valP_i.
  - `IJXX: f_valC_i (always predicted taken).
  - `IRET with spec count>0: stack top, f_ras_hit_o=1; pop.
  - `IRET with count=0: f_valP_i, f_ras_hit_o=0; no pop.
  - Any other icode: f_valP_i.
- F register: on a rising edge with F_stall_i=0, F_predPC_o <= f_predPC. With F_stall_i=1 it holds. Latency is 1 cycle from fetch to F_predPC_o.
- RAS is circular: push writes entry[ptr] and ptr<=ptr+1 (wrap mod RAS_DEPTH); pop ptr<=ptr-1 (wrap). Count saturates at RAS_DEPTH on push, so the oldest entry is overwritten when full, and floors at 0 on pop.
- Committed copy (ptr, count only): W_icode_i=`ICALL applies +1; W_icode_i=`IRET applies -1. Both use the same saturate/floor rules.
- Mispredict (M_icode_i=`IJXX && !M_Cnd_i):
  - Spec ptr/count are reloaded from the committed values, including this cycle's W update.
  - The current fetch's push/pop is then applied on top, because f_pc this cycle is the corrected M_valA path.
  - This is the only repair. Entry contents are not restored; stale targets are tolerated and corrected by the W ret redirect.
- Ordering within one cycle: restore first, then the fetch op. A fetch op is suppressed when F_stall_i=1, but a restore still happens under stall.
- No internal FSM beyond the stack. Hazard-control behaviour for ret is unchanged.

Decomposition:
- The icode constants `ICALL, `IRET, `IJXX stay in `define.v`. Add `RAS_DEPTH_DEF there.
- Natural sub-module: ras_stack (storage, spec/committed pointers, count saturation, restore). The top level holds the prediction mux and the F register.

Test Plan:
- Reset: rst_n_i low mid-run with F_predPC_o=0x40 -> F_predPC_o=0 and ras_count_o=0 immediately, without waiting for a clock edge.
- call with valC=0x100, valP=0x20A, no stall -> next cycle F_predPC_o=0x100, ras_count_o=1. Later ret fetched -> f_ras_hit_o=1, F_predPC_o=0x20A, count=0.
- ret with empty RAS, valP=0x31 -> F_predPC_o=0x31, f_ras_hit_o=0, count stays 0.
- 9 calls with RAS_DEPTH=8 (valP 0x10..0x90), then 8 rets -> predictions 0x90 down to 0x20, count 8->0. A 9th ret -> count 0, predicts its own valP.
- Mispredict restore:
  - Setup: committed count=1, 2 speculative calls, then M_icode=IJXX, M_Cnd=0 while fetching a non-call.
  - Required: ras_count_o=1 next cycle.
  - Repeat with a call fetched in the same cycle -> ras_count_o=2.
- F_stall_i=1 while call fetched -> F_predPC_o and ras_count_o unchanged. Deassert stall -> push happens once.

Source files
------------

// File: rtl/fetch_pred_pc_pkg.sv
// fetch_pred_pc_pkg
// Shared definitions for the fetch-side PC predictor: Y86-64 instruction
// codes and the default return-address-stack depth.
package fetch_pred_pc_pkg;

    // Y86-64 icode encodings
    typedef enum logic [3:0] {
        IHALT   = 4'h0,
        INOP    = 4'h1,
        IRRMOVQ = 4'h2,
        IIRMOVQ = 4'h3,
        IRMMOVQ = 4'h4,
        IMRMOVQ = 4'h5,
        IOPQ    = 4'h6,
        IJXX    = 4'h7,
        ICALL   = 4'h8,
        IRET    = 4'h9,
        IPUSHQ  = 4'hA,
        IPOPQ   = 4'hB
    } icode_e;

    localparam int unsigned RAS_DEPTH_DEF = 8;
    localparam int unsigned RAS_PTR_W_DEF = 3;

endpackage

// File: rtl/fetch_pred_pc_ras_stack.sv
// fetch_pred_pc_ras_stack
// Circular return-address stack with a speculative pointer/count (driven by
// fetch) and a committed pointer/count (driven by W-stage call/ret). On a
// branch mispredict the speculative state is reloaded from the committed
// state; entry contents are never repaired.
//
// Ports:
//   clk_i, rst_n_i   clock, async active-low reset
//   push_i           push push_data_i (fetch of a call, not stalled)
//   pop_i            pop (fetch of a predicted ret, not stalled)
//   push_data_i      return address to push
//   restore_i        reload speculative state from committed state
//   w_call_i/w_ret_i committed call/ret in W
//   top_o            entry below the speculative pointer
//   count_o          speculative occupancy
module fetch_pred_pc_ras_stack #(
    parameter int unsigned RAS_DEPTH = 8,
    parameter int unsigned PTR_W     = 3
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [63:0]      push_data_i,
    input  logic             restore_i,
    input  logic             w_call_i,
    input  logic             w_ret_i,
    output logic [63:0]      top_o,
    output logic [PTR_W:0]   count_o
);

    localparam logic [PTR_W:0] CNT_MAX = (PTR_W + 1)'(RAS_DEPTH);

    logic [63:0]      mem_q [RAS_DEPTH];

    logic [PTR_W-1:0] spec_ptr_q, spec_ptr_d;
    logic [PTR_W:0]   spec_cnt_q, spec_cnt_d;
    logic [PTR_W-1:0] com_ptr_q,  com_ptr_d;
    logic [PTR_W:0]   com_cnt_q,  com_cnt_d;

    // State the fetch op is applied on top of: committed (with this cycle's
    // W update) after a mispredict, otherwise the current speculative state.
    logic [PTR_W-1:0] base_ptr;
    logic [PTR_W:0]   base_cnt;

    always_comb begin
        com_ptr_d = com_ptr_q;
        com_cnt_d = com_cnt_q;
        if (w_call_i) begin
            com_ptr_d = com_ptr_q + 1'b1;
            if (com_cnt_q != CNT_MAX) begin
                com_cnt_d = com_cnt_q + 1'b1;
            end
        end else if (w_ret_i && (com_cnt_q != '0)) begin
            com_ptr_d = com_ptr_q - 1'b1;
            com_cnt_d = com_cnt_q - 1'b1;
        end
    end

    always_comb begin
        base_ptr   = restore_i ? com_ptr_d : spec_ptr_q;
        base_cnt   = restore_i ? com_cnt_d : spec_cnt_q;
        spec_ptr_d = base_ptr;
        spec_cnt_d = base_cnt;
        if (push_i) begin
            // When full the pointer still advances, overwriting the oldest entry.
            spec_ptr_d = base_ptr + 1'b1;
            if (base_cnt != CNT_MAX) begin
                spec_cnt_d = base_cnt + 1'b1;
            end
        end else if (pop_i && (base_cnt != '0)) begin
            spec_ptr_d = base_ptr - 1'b1;
            spec_cnt_d = base_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            spec_ptr_q <= '0;
            spec_cnt_q <= '0;
            com_ptr_q  <= '0;
            com_cnt_q  <= '0;
        end else begin
            spec_ptr_q <= spec_ptr_d;
            spec_cnt_q <= spec_cnt_d;
            com_ptr_q  <= com_ptr_d;
            com_cnt_q  <= com_cnt_d;
        end
    end

    // Entry storage is not reset; it is only read while count is non-zero.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[base_ptr] <= push_data_i;
        end
    end

    assign top_o   = mem_q[spec_ptr_q - 1'b1];
    assign count_o = spec_cnt_q;

endmodule

// File: rtl/fetch_pred_pc.sv
// fetch_pred_pc
// Produces F_predPC: predicts the next PC from the instruction being fetched
// and registers it in the F pipeline register. ret is predicted from a
// return-address stack; wrong guesses are fixed by the existing M/W redirects.
//
// Ports:
//   clk_i, rst_n_i     clock, async active-low reset
//   F_stall_i          hold F register; suppresses RAS push/pop
//   f_icode_i          icode of fetched instruction
//   f_instr_valid_i    fetched instruction is valid
//   f_valC_i/f_valP_i  constant word / fall-through PC
//   M_icode_i/M_Cnd_i  M-stage jXX outcome (not-taken = mispredict)
//   W_icode_i          W-stage icode (commit of call/ret)
//   F_predPC_o         registered predicted PC
//   f_ras_hit_o        current ret is predicted from the RAS
//   ras_count_o        speculative RAS occupancy
module fetch_pred_pc
    import fetch_pred_pc_pkg::*;
#(
    parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF,
    parameter int unsigned PTR_W     = RAS_PTR_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             F_stall_i,
    input  logic [3:0]       f_icode_i,
    input  logic             f_instr_valid_i,
    input  logic [63:0]      f_valC_i,
    input  logic [63:0]      f_valP_i,
    input  logic [3:0]       M_icode_i,
    input  logic             M_Cnd_i,
    input  logic [3:0]       W_icode_i,
    output logic [63:0]      F_predPC_o,
    output logic             f_ras_hit_o,
    output logic [PTR_W:0]   ras_count_o
);

    logic [63:0]    F_predPC_q, F_predPC_d;
    logic [63:0]    ras_top;
    logic [PTR_W:0] ras_count;
    logic           is_call, is_ret, ras_hit;
    logic           ras_push, ras_pop, restore;

    assign is_call  = f_instr_valid_i && (f_icode_i == ICALL);
    assign is_ret   = f_instr_valid_i && (f_icode_i == IRET);
    assign ras_hit  = is_ret && (ras_count != '0);
    assign ras_push = is_call && !F_stall_i;
    assign ras_pop  = ras_hit && !F_stall_i;
    assign restore  = (M_icode_i == IJXX) && !M_Cnd_i;

    always_comb begin
        F_predPC_d = f_valP_i;
        if (f_instr_valid_i) begin
            if ((f_icode_i == ICALL) || (f_icode_i == IJXX)) begin
                F_predPC_d = f_valC_i;
            end else if (ras_hit) begin
                F_predPC_d = ras_top;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            F_predPC_q <= '0;
        end else if (!F_stall_i) begin
            F_predPC_q <= F_predPC_d;
        end
    end

    fetch_pred_pc_ras_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .PTR_W     (PTR_W)
    ) u_ras (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (f_valP_i),
        .restore_i   (restore),
        .w_call_i    (W_icode_i == ICALL),
        .w_ret_i     (W_icode_i == IRET),
        .top_o       (ras_top),
        .count_o     (ras_count)
    );

    assign F_predPC_o  = F_predPC_q;
    assign f_ras_hit_o = ras_hit;
    assign ras_count_o = ras_count;

endmodule
